// File: rtl/reset_seq_gen.sv
// Per-domain reset sequencer: holds all domain resets low, then releases them
// one at a time in index order, waiting for each domain's synchronized ack.
module reset_seq_gen #(
  parameter int unsigned NUM_DOM  = 4,
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned GAP_CYC  = 4,
  parameter int unsigned TO_CYC   = 256,
  parameter int unsigned CNT_W    = 9
) (
  input  logic               clk,
  input  logic               inreset_,
  input  logic               sw_req,
  input  logic               test_mode,
  input  logic               direct_reset_,
  input  logic [NUM_DOM-1:0] dom_ack,
  output logic [NUM_DOM-1:0] dom_reset_,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic [3:0]         err_dom
);

  typedef enum logic [2:0] {
    IDLE,
    ASSERT,
    RELEASE,
    WAIT_ACK,
    GAP,
    DONE
  } state_e;

  localparam int unsigned GAP_LAST_I = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LAST_I);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYC - 1);
  localparam logic [3:0]       LAST_IDX  = 4'(NUM_DOM - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_rst_q, dom_rst_d;
  logic               terr_q, terr_d;
  logic [3:0]         err_dom_q, err_dom_d;
  logic [NUM_DOM-1:0] ack_meta_q, ack_sync_q;

  logic [CNT_W-1:0]   cnt_inc;
  logic               ack_cur;
  logic               advance;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    ack_cur = 1'b0;
    for (int unsigned i = 0; i < NUM_DOM; i++) begin
      if (idx_q == 4'(i)) ack_cur = ack_sync_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dom_rst_d = dom_rst_q;
    terr_d    = terr_q;
    err_dom_d = err_dom_q;
    advance   = 1'b0;

    case (state_q)
      IDLE: begin
        dom_rst_d = '1;
        if (sw_req) begin
          state_d   = ASSERT;
          dom_rst_d = '0;
          cnt_d     = '0;
          idx_d     = '0;
          terr_d    = 1'b0;
          err_dom_d = '0;
        end
      end
      ASSERT: begin
        dom_rst_d = '0;
        if (cnt_q >= HOLD_LAST) begin
          state_d = RELEASE;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RELEASE: begin
        for (int unsigned i = 0; i < NUM_DOM; i++) begin
          if (idx_q == 4'(i)) dom_rst_d[i] = 1'b1;
        end
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_cur) begin
          advance = 1'b1;
        end else if (cnt_q >= TO_LAST) begin
          // Timed-out domain is treated as acknowledged; only the first offender is recorded.
          terr_d = 1'b1;
          if (!terr_q) err_dom_d = idx_q;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
        if (advance) begin
          cnt_d = '0;
          if (idx_q >= LAST_IDX) begin
            state_d = DONE;
          end else if (GAP_CYC == 0) begin
            idx_d   = idx_q + 4'd1;
            state_d = RELEASE;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (cnt_q >= GAP_LAST) begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = '0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = ASSERT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!inreset_) begin
      state_q    <= ASSERT;
      cnt_q      <= '0;
      idx_q      <= '0;
      dom_rst_q  <= '0;
      terr_q     <= 1'b0;
      err_dom_q  <= '0;
      ack_meta_q <= '0;
      ack_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      dom_rst_q  <= dom_rst_d;
      terr_q     <= terr_d;
      err_dom_q  <= err_dom_d;
      ack_meta_q <= dom_ack;
      ack_sync_q <= ack_meta_q;
    end
  end

  // DFT bypass overrides only the reset outputs; the sequencer keeps running.
  assign dom_reset_  = test_mode ? {NUM_DOM{direct_reset_}} : dom_rst_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign timeout_err = terr_q;
  assign err_dom     = err_dom_q;

endmodule

// File: tb/tb_reset_seq_gen.sv
// Scoreboard bench for reset_seq_gen: stimulus queues expected release/done
// events with hand-computed cycle offsets; a monitor pops them as they occur.
module tb_reset_seq_gen;

  localparam int N = 4;
  // Hand-computed timing for HOLD=16, GAP=4, TO=256 with acks tied to resets.
  localparam int REL0   = 17;  // start edge -> first release
  localparam int ACK_LT = 3;   // release -> ack decision (2 sync + 1)
  localparam int TO_LT  = 256; // release -> timeout decision
  localparam int NEXT   = 5;   // decision -> next release (4 GAP + 1 RELEASE)

  logic         clk = 1'b0;
  logic         inreset_ = 1'b0;
  logic         sw_req = 1'b0;
  logic         test_mode = 1'b0;
  logic         direct_reset_ = 1'b0;
  logic [N-1:0] ack_en = '1;
  logic [N-1:0] dom_ack;
  logic [N-1:0] dom_reset_;
  logic         busy, done, timeout_err;
  logic [3:0]   err_dom;

  typedef struct {
    int         kind;  // 0 = domain release, 1 = done pulse
    int         idx;
    int         cyc;
    logic       terr;
    logic [3:0] edom;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_miss = 0;
  int  n_done = 0;
  bit  mon_en = 1'b0;
  logic [N-1:0] prev = '0;

  reset_seq_gen #(
    .NUM_DOM(N), .HOLD_CYC(16), .GAP_CYC(4), .TO_CYC(256), .CNT_W(9)
  ) dut (
    .clk(clk), .inreset_(inreset_), .sw_req(sw_req), .test_mode(test_mode),
    .direct_reset_(direct_reset_), .dom_ack(dom_ack), .dom_reset_(dom_reset_),
    .busy(busy), .done(done), .timeout_err(timeout_err), .err_dom(err_dom)
  );

  assign dom_ack = dom_reset_ & ack_en;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_sched(input int s, input logic [N-1:0] stuck);
    int   t, dec, first;
    ev_t  e;
    first = -1;
    t = s + REL0;
    for (int d = 0; d < N; d++) begin
      e.kind = 0; e.idx = d; e.cyc = t; e.terr = 1'b0; e.edom = '0;
      sb.push_back(e);
      dec = t + (stuck[d] ? TO_LT : ACK_LT);
      if (stuck[d] && first < 0) first = d;
      if (d == N - 1) begin
        e.kind = 1; e.idx = 0; e.cyc = dec; e.terr = |stuck;
        e.edom = (first < 0) ? 4'd0 : 4'(first);
        sb.push_back(e);
      end else begin
        t = dec + NEXT;
      end
    end
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while (sb.size() != 0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d events still pending after %0d cycles", sb.size(), maxc);
      sb.delete();
    end
  endtask

  task automatic idle_chk(input logic terr, input logic [3:0] edom);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_rst", 32'(dom_reset_), 32'hF);
    chk("idle_terr", 32'(timeout_err), 32'(terr));
    chk("idle_edom", 32'(err_dom), 32'(edom));
  endtask

  // Issues an sw_req pulse; returns the edge at which ASSERT begins.
  task automatic start_sw(input logic [N-1:0] stuck, output int s);
    s = cyc + 1;
    push_sched(s, stuck);
    sw_req = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
    chk("sw_rst_drop", 32'(dom_reset_), 32'h0);
    chk("sw_busy", 32'(busy), 32'd1);
    chk("sw_terr_clr", 32'(timeout_err), 32'd0);
    chk("sw_edom_clr", 32'(err_dom), 32'd0);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      for (int i = 0; i < N; i++) begin
        if (dom_reset_[i] === 1'b1 && prev[i] === 1'b0) begin
          if (sb.size() == 0) begin
            chk($sformatf("unexpected_rel%0d", i), 32'd1, 32'd0);
          end else begin
            ev_t e;
            e = sb.pop_front();
            chk("rel_kind", 32'(e.kind), 32'd0);
            chk($sformatf("rel_idx_at_%0d", cyc), 32'(i), 32'(e.idx));
            chk($sformatf("rel%0d_cyc", i), 32'(cyc), 32'(e.cyc));
          end
        end
      end
      if (done === 1'b1) begin
        n_done++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          chk("done_kind", 32'(e.kind), 32'd1);
          chk("done_cyc", 32'(cyc), 32'(e.cyc));
          chk("done_terr", 32'(timeout_err), 32'(e.terr));
          chk("done_edom", 32'(err_dom), 32'(e.edom));
          chk("done_busy", 32'(busy), 32'd1);
        end
      end
    end
    prev = dom_reset_;
  end

  initial begin
    int s;
    int nd;
    repeat (3) @(negedge clk);
    chk("rst_dom", 32'(dom_reset_), 32'h0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_edom", 32'(err_dom), 32'd0);

    // Power-up sequence, all acks follow their resets.
    push_sched(cyc, 4'b0000);
    mon_en = 1'b1;
    inreset_ = 1'b1;
    drain(100);
    idle_chk(1'b0, 4'd0);

    // Domain 2 never acks.
    ack_en = 4'b1011;
    start_sw(4'b0100, s);
    drain(400);
    idle_chk(1'b1, 4'd2);

    // Domains 1 and 3 never ack: first offender kept; prior error cleared on start.
    ack_en = 4'b0101;
    start_sw(4'b1010, s);
    drain(700);
    idle_chk(1'b1, 4'd1);

    // Second sw_req during WAIT_ACK of domain 0 is ignored.
    ack_en = '1;
    nd = n_done;
    start_sw(4'b0000, s);
    repeat (18) @(negedge clk);
    sw_req = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
    drain(100);
    repeat (10) @(negedge clk);
    chk("one_done", 32'(n_done - nd), 32'd1);
    chk("no_rerun_busy", 32'(busy), 32'd0);

    // inreset_ pulse during GAP after domain 1 restarts the whole sequence.
    start_sw(4'b0000, s);
    while (cyc < s + 29) @(negedge clk);
    inreset_ = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_dom", 32'(dom_reset_), 32'h0);
    chk("midrst_busy", 32'(busy), 32'd1);
    push_sched(cyc, 4'b0000);
    inreset_ = 1'b1;
    drain(100);
    idle_chk(1'b0, 4'd0);

    // DFT bypass during ASSERT; FSM timing must be undisturbed afterwards.
    start_sw(4'b0000, s);
    mon_en = 1'b0;
    test_mode = 1'b1;
    direct_reset_ = 1'b1;
    #1 chk("tm_hi", 32'(dom_reset_), 32'hF);
    chk("tm_busy", 32'(busy), 32'd1);
    direct_reset_ = 1'b0;
    #1 chk("tm_lo", 32'(dom_reset_), 32'h0);
    direct_reset_ = 1'b1;
    #1 chk("tm_hi2", 32'(dom_reset_), 32'hF);
    @(negedge clk);
    test_mode = 1'b0;
    #1 chk("tm_restore", 32'(dom_reset_), 32'h0);
    mon_en = 1'b1;
    drain(100);
    idle_chk(1'b0, 4'd0);
    test_mode = 1'b1;
    direct_reset_ = 1'b0;
    #1 chk("tm_idle_lo", 32'(dom_reset_), 32'h0);
    test_mode = 1'b0;
    #1 chk("tm_idle_restore", 32'(dom_reset_), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
